branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating predictors, sitting beside the IF stage. It looks up the fetch PC and drives the next-PC prediction. It also registers the lookup result alongside the IF/ID register, producing `PcMatchValid` and `CtrlIn` for the branch unit. It accepts the branch unit's update (`WriteEnable`, `CtrlOut`) to allocate entries or retrain them.

## Interface
- `ENTRIES`, default 16: number of entries; power of two, minimum 2.
- `PC_W`, default 32: PC and target width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_IF_PC` in PC_W: current fetch PC.
- `i_Stall` in 1: IF/ID stall (o_IFID_Stall); holds ID-side outputs.
- `i_Flush` in 1: IF/ID flush (Flush_IF_ID); clears ID-side outputs.
- `i_Inval` in 1: synchronous invalidate of all entries.
- `o_IF_Hit` in→out 1: combinational; valid entry whose tag matches i_IF_PC.
- `o_IF_PredTaken` out 1: o_IF_Hit & counter[1].
- `o_IF_Target` out PC_W: stored target; 0 when no hit.
- `o_PcMatchValid` out 1: registered o_IF_Hit, aligned with IF/ID.
- `o_CtrlIn` out 2: registered counter of the hit entry; 2'b01 on miss.
- `o_ID_Target` out PC_W: registered o_IF_Target.
- `i_WriteEnable` in 1: update strobe from the branch unit.
- `i_Upd_PC` in PC_W: PC of the resolved branch.
- `i_Upd_Target` in PC_W: resolved target.
- `i_CtrlOut` in 2: new counter value computed by the branch unit.

## Operation
- Index = PC[IDX_W+1:2], where IDX_W = log2(ENTRIES). Tag = PC[PC_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds: valid, tag, target, ctr[1:0]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from i_IF_PC.
- Update: when i_WriteEnable=1, entry[idx(i_Upd_PC)] is written on the clock edge with valid=1, tag, target=i_Upd_Target, ctr=i_CtrlOut.
  - The update unconditionally overwrites any previous tag (direct-mapped replacement).
  - The block does no counter arithmetic; the counter value is owned by the branch unit.
- i_Inval clears every valid bit at the edge.
  - If i_Inval and i_WriteEnable occur in the same cycle, invalidate wins; the written entry ends invalid.
- ID-side register priority is rst > i_Flush > i_Stall > load.
  - i_Flush: o_PcMatchValid=0, o_CtrlIn=01, o_ID_Target=0.
  - i_Stall: hold all values.
  - Load: capture the IF lookup.
- i_Flush and i_Stall together: flush wins.

## Timing
- Reset (async, immediate): all valid bits=0, o_PcMatchValid=0, o_CtrlIn=2'b01, o_ID_Target=0. Combinational IF outputs are then 0 (all misses).
- Lookup latency: IF outputs are available in the same cycle; ID outputs follow 1 cycle after the edge.
- Update latency: the written entry is visible to lookup starting the cycle after the write edge.
- Same-cycle update and lookup to the same index: the lookup sees the old contents, unless BTB_BYPASS_EN is defined (see Configuration).
- If rst asserts mid-update, the write is dropped.

## Configuration
- Macro: `BTB_BYPASS_EN`.
- Defined: when i_WriteEnable=1 and idx(i_Upd_PC)==idx(i_IF_PC) in the same cycle, lookup uses the incoming {1, tag, i_Upd_Target, i_CtrlOut} instead of array contents. Hit is still decided by the tag compare against the incoming tag. i_Inval suppresses the bypass.
- Undefined: no bypass; lookup always reads the stored array.

## Structure
- Package `btb_pkg` contains:
  - the counter encoding constants (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST);
  - reset counter value CTR_WNT;
  - the entry struct typedef `btb_entry_t` {valid, tag, target, ctr};
  - helper functions for index and tag extraction, parameterised on IDX_W.
- One sub-module, `btb_storage`: the entry array with async valid-clear, a sync write port and a combinational read port. The top level holds the tag compare, the bypass mux and the ID-side registers.

## Test plan
- Reset, then lookup of PC 0x100 → o_IF_Hit=0, o_IF_Target=0; next cycle o_PcMatchValid=0, o_CtrlIn=01.
- Write PC 0x100, target 0x200, ctr 10; next cycle lookup 0x100 → o_IF_Hit=1, o_IF_PredTaken=1, o_IF_Target=0x200; one cycle later o_CtrlIn=10.
- With the entry present, lookup of alias 0x100+4·ENTRIES (same index, different tag) → miss. Writing that alias → a subsequent lookup of 0x100 misses.
- Lookup hits, then i_Stall held 3 cycles while i_IF_PC changes → o_PcMatchValid/o_CtrlIn/o_ID_Target unchanged. Assert i_Flush together with i_Stall → o_PcMatchValid=0, o_CtrlIn=01.
- Write 0x140 (ctr 11) in the same cycle as lookup of 0x140 → hit=0 without BTB_BYPASS_EN; hit=1 and target forwarded with it.
- Fill 4 entries, assert i_Inval together with a write to a fifth PC → all 5 PCs miss on the following cycles.

Source files
------------

// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the branch target buffer:
//   - 2-bit predictor encodings and the counter value used on miss/reset/flush
//   - btb_entry_t: one entry {valid, tag, target, ctr}. Tag and target fields
//     are sized to BTB_FIELD_W so the struct serves any PC_W <= 64. Narrower
//     values are zero-extended into the fields.
//   - btb_index / btb_tag: PC field extraction for a given index width.
//     Both ignore PC[1:0].
// -----------------------------------------------------------------------------
package btb_pkg;

  localparam int BTB_FIELD_W = 64;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  // Index = PC[idx_w+1:2], returned right-aligned
  function automatic logic [BTB_FIELD_W-1:0] btb_index(input logic [BTB_FIELD_W-1:0] pc,
                                                       input int                     idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag = PC[MSB:idx_w+2], returned right-aligned
  function automatic logic [BTB_FIELD_W-1:0] btb_tag(input logic [BTB_FIELD_W-1:0] pc,
                                                     input int                     idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_storage.sv
// -----------------------------------------------------------------------------
// btb_storage
// Entry array of the branch target buffer.
// Only the valid bits carry reset, so an async reset clears every entry at
// once. Tag, target and counter are plain storage.
//   clk, rst    : clock, async active-high reset (clears valid bits)
//   inval       : clear all valid bits at the edge; it overrides a write
//   wr_en       : write strobe
//   wr_idx      : entry written
//   wr_entry    : entry contents. The valid field is ignored because a write
//                 always sets valid.
//   rd_idx      : combinational read index
//   rd_entry    : stored entry at rd_idx, with fields zero-extended
// -----------------------------------------------------------------------------
module btb_storage
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inval,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry
);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [PC_W-1:0]    target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];
  logic               data_we_s;

  // Data is written only when the entry also becomes valid
  always_comb begin
    data_we_s = wr_en & ~inval;
  end

  // Valid bits: reset, then invalidate, then write-allocate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (inval) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Entry payload write port
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      tag_r[wr_idx]    <= TAG_W'(wr_entry.tag);
      target_r[wr_idx] <= PC_W'(wr_entry.target);
      ctr_r[wr_idx]    <= wr_entry.ctr;
    end
  end

  // Combinational read port
  always_comb begin
    rd_entry.valid  = valid_r[rd_idx];
    rd_entry.tag    = BTB_FIELD_W'(tag_r[rd_idx]);
    rd_entry.target = BTB_FIELD_W'(target_r[rd_idx]);
    rd_entry.ctr    = ctr_r[rd_idx];
  end

endmodule

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with 2-bit predictor state, placed beside the IF stage.
// Lookup is combinational from the fetch PC. The result is also registered
// alongside IF/ID for the branch unit. The branch unit owns the counter
// arithmetic; this block only stores the value it is handed.
//
// Optional feature: `BTB_BYPASS_EN. When it is defined, a write and a lookup
// to the same index in the same cycle forward the incoming entry to the
// lookup. i_Inval suppresses this forwarding.
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   i_IF_PC         : fetch PC
//   i_Stall/i_Flush : IF/ID hold / clear (flush wins)
//   i_Inval         : invalidate all entries
//   o_IF_Hit, o_IF_PredTaken, o_IF_Target : combinational prediction
//   o_PcMatchValid, o_CtrlIn, o_ID_Target : registered copy for ID
//   i_WriteEnable, i_Upd_PC, i_Upd_Target, i_CtrlOut : update from branch unit
// -----------------------------------------------------------------------------
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] i_IF_PC,
  input  logic            i_Stall,
  input  logic            i_Flush,
  input  logic            i_Inval,
  output logic            o_IF_Hit,
  output logic            o_IF_PredTaken,
  output logic [PC_W-1:0] o_IF_Target,
  output logic            o_PcMatchValid,
  output logic [1:0]      o_CtrlIn,
  output logic [PC_W-1:0] o_ID_Target,
  input  logic            i_WriteEnable,
  input  logic [PC_W-1:0] i_Upd_PC,
  input  logic [PC_W-1:0] i_Upd_Target,
  input  logic [1:0]      i_CtrlOut
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] upd_idx_s;
  btb_entry_t       upd_entry_s;
  btb_entry_t       rd_entry_s;
  btb_entry_t       lookup_entry_s;
  logic             hit_s;
  logic [PC_W-1:0]  if_target_s;
  logic [1:0]       if_ctr_s;

  logic             pc_match_valid_r;
  logic [1:0]       ctrl_in_r;
  logic [PC_W-1:0]  id_target_r;

  // Index extraction for lookup and update, plus the incoming entry image
  always_comb begin
    if_idx_s           = IDX_W'(btb_index(BTB_FIELD_W'(i_IF_PC), IDX_W));
    upd_idx_s          = IDX_W'(btb_index(BTB_FIELD_W'(i_Upd_PC), IDX_W));
    upd_entry_s.valid  = 1'b1;
    upd_entry_s.tag    = btb_tag(BTB_FIELD_W'(i_Upd_PC), IDX_W);
    upd_entry_s.target = BTB_FIELD_W'(i_Upd_Target);
    upd_entry_s.ctr    = i_CtrlOut;
  end

  btb_storage #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .PC_W    (PC_W)
  ) u_storage (
    .clk      (clk),
    .rst      (rst),
    .inval    (i_Inval),
    .wr_en    (i_WriteEnable),
    .wr_idx   (upd_idx_s),
    .wr_entry (upd_entry_s),
    .rd_idx   (if_idx_s),
    .rd_entry (rd_entry_s)
  );

`ifdef BTB_BYPASS_EN
  // Same-index write forwards the incoming entry unless an invalidate is pending
  always_comb begin
    if (i_WriteEnable && !i_Inval && (upd_idx_s == if_idx_s)) begin
      lookup_entry_s = upd_entry_s;
    end else begin
      lookup_entry_s = rd_entry_s;
    end
  end
`else
  // Lookup always sees the stored array
  always_comb begin
    lookup_entry_s = rd_entry_s;
  end
`endif

  // Tag compare and prediction; fields are compared at full width because
  // both sides are zero-extended
  always_comb begin
    hit_s = lookup_entry_s.valid &&
            (lookup_entry_s.tag == btb_tag(BTB_FIELD_W'(i_IF_PC), IDX_W));
    if (hit_s) begin
      if_target_s = PC_W'(lookup_entry_s.target);
      if_ctr_s    = lookup_entry_s.ctr;
    end else begin
      if_target_s = {PC_W{1'b0}};
      if_ctr_s    = CTR_RESET;
    end
    o_IF_Hit       = hit_s;
    o_IF_PredTaken = hit_s & if_ctr_s[1];
    o_IF_Target    = if_target_s;
  end

  // IF/ID-aligned copy of the lookup: reset > flush > stall > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_match_valid_r <= 1'b0;
      ctrl_in_r        <= CTR_RESET;
      id_target_r      <= {PC_W{1'b0}};
    end else if (i_Flush) begin
      pc_match_valid_r <= 1'b0;
      ctrl_in_r        <= CTR_RESET;
      id_target_r      <= {PC_W{1'b0}};
    end else if (i_Stall) begin
      pc_match_valid_r <= pc_match_valid_r;
      ctrl_in_r        <= ctrl_in_r;
      id_target_r      <= id_target_r;
    end else begin
      pc_match_valid_r <= hit_s;
      ctrl_in_r        <= if_ctr_s;
      id_target_r      <= if_target_s;
    end
  end

  // Registered ID-side outputs
  always_comb begin
    o_PcMatchValid = pc_match_valid_r;
    o_CtrlIn       = ctrl_in_r;
    o_ID_Target    = id_target_r;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, PC_W=32).
// Inputs change on the falling edge. Combinational outputs are sampled 1
// time unit later. ID-side outputs are sampled on the next falling edge.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] i_IF_PC;
  logic        i_Stall;
  logic        i_Flush;
  logic        i_Inval;
  logic        o_IF_Hit;
  logic        o_IF_PredTaken;
  logic [31:0] o_IF_Target;
  logic        o_PcMatchValid;
  logic [1:0]  o_CtrlIn;
  logic [31:0] o_ID_Target;
  logic        i_WriteEnable;
  logic [31:0] i_Upd_PC;
  logic [31:0] i_Upd_Target;
  logic [1:0]  i_CtrlOut;

  int total_cnt = 0;
  int pass_cnt  = 0;

  branch_target_buffer #(.ENTRIES(16), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_IF_PC        (i_IF_PC),
    .i_Stall        (i_Stall),
    .i_Flush        (i_Flush),
    .i_Inval        (i_Inval),
    .o_IF_Hit       (o_IF_Hit),
    .o_IF_PredTaken (o_IF_PredTaken),
    .o_IF_Target    (o_IF_Target),
    .o_PcMatchValid (o_PcMatchValid),
    .o_CtrlIn       (o_CtrlIn),
    .o_ID_Target    (o_ID_Target),
    .i_WriteEnable  (i_WriteEnable),
    .i_Upd_PC       (i_Upd_PC),
    .i_Upd_Target   (i_Upd_Target),
    .i_CtrlOut      (i_CtrlOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic write_entry(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ctr);
    @(negedge clk);
    i_WriteEnable = 1'b1;
    i_Upd_PC      = pc;
    i_Upd_Target  = tgt;
    i_CtrlOut     = ctr;
    @(negedge clk);
    i_WriteEnable = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit);
    i_IF_PC = pc;
    #1;
    chk(tag, {31'd0, o_IF_Hit}, {31'd0, exp_hit});
  endtask

  initial begin
    rst           = 1'b1;
    i_IF_PC       = 32'h0;
    i_Stall       = 1'b0;
    i_Flush       = 1'b0;
    i_Inval       = 1'b0;
    i_WriteEnable = 1'b0;
    i_Upd_PC      = 32'h0;
    i_Upd_Target  = 32'h0;
    i_CtrlOut     = 2'b00;
    #1;
    chk("rst_pcmv",  {31'd0, o_PcMatchValid}, 32'd0);
    chk("rst_ctrl",  {30'd0, o_CtrlIn},       32'd1);
    chk("rst_idtgt", o_ID_Target,             32'd0);

    // Lookup on an empty table
    @(negedge clk);
    rst     = 1'b0;
    i_IF_PC = 32'h100;
    #1;
    chk("empty_hit", {31'd0, o_IF_Hit}, 32'd0);
    chk("empty_tgt", o_IF_Target,       32'd0);
    @(negedge clk);
    chk("empty_pcmv", {31'd0, o_PcMatchValid}, 32'd0);
    chk("empty_ctrl", {30'd0, o_CtrlIn},       32'd1);

    // Allocate 0x100 -> 0x200, weak-taken; lookup meanwhile on another index
    i_IF_PC = 32'h104;
    write_entry(32'h100, 32'h200, 2'b10);
    i_IF_PC = 32'h100;
    #1;
    chk("wr_hit", {31'd0, o_IF_Hit},       32'd1);
    chk("wr_pt",  {31'd0, o_IF_PredTaken}, 32'd1);
    chk("wr_tgt", o_IF_Target,             32'h200);
    @(negedge clk);
    chk("wr_pcmv",  {31'd0, o_PcMatchValid}, 32'd1);
    chk("wr_ctrl",  {30'd0, o_CtrlIn},       32'd2);
    chk("wr_idtgt", o_ID_Target,             32'h200);

    // Alias 0x140 has the same index and a different tag
    look("alias_miss", 32'h140, 1'b0);
    chk("alias_tgt", o_IF_Target, 32'd0);
    i_IF_PC = 32'h104;
    write_entry(32'h140, 32'h280, 2'b01);
    look("evicted_miss", 32'h100, 1'b0);
    look("alias_hit", 32'h140, 1'b1);
    chk("alias_pt",  {31'd0, o_IF_PredTaken}, 32'd0);
    chk("alias_tgt2", o_IF_Target, 32'h280);

    // Re-allocate 0x100 strong-taken, then exercise stall and flush
    i_IF_PC = 32'h104;
    write_entry(32'h100, 32'h200, 2'b11);
    i_IF_PC = 32'h100;
    @(negedge clk);
    chk("ld_pcmv", {31'd0, o_PcMatchValid}, 32'd1);
    chk("ld_ctrl", {30'd0, o_CtrlIn},       32'd3);
    i_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_IF_PC = 32'h104 + 32'(k * 4);
      @(negedge clk);
      chk("stall_pcmv",  {31'd0, o_PcMatchValid}, 32'd1);
      chk("stall_ctrl",  {30'd0, o_CtrlIn},       32'd3);
      chk("stall_idtgt", o_ID_Target,             32'h200);
    end
    i_Flush = 1'b1;
    @(negedge clk);
    chk("flush_pcmv",  {31'd0, o_PcMatchValid}, 32'd0);
    chk("flush_ctrl",  {30'd0, o_CtrlIn},       32'd1);
    chk("flush_idtgt", o_ID_Target,             32'd0);
    i_Flush = 1'b0;
    i_Stall = 1'b0;

    // Same-cycle write and lookup of 0x140; index 0 holds the 0x100 tag
    i_WriteEnable = 1'b1;
    i_Upd_PC      = 32'h140;
    i_Upd_Target  = 32'h500;
    i_CtrlOut     = 2'b11;
    i_IF_PC       = 32'h140;
    #1;
`ifdef BTB_BYPASS_EN
    chk("same_cyc_hit", {31'd0, o_IF_Hit}, 32'd1);
    chk("same_cyc_tgt", o_IF_Target,       32'h500);
`else
    chk("same_cyc_hit", {31'd0, o_IF_Hit}, 32'd0);
    chk("same_cyc_tgt", o_IF_Target,       32'd0);
`endif
    @(negedge clk);
    i_WriteEnable = 1'b0;
    look("after_wr_hit", 32'h140, 1'b1);
    chk("after_wr_tgt", o_IF_Target, 32'h500);

    // Fill four entries, then invalidate together with a fifth write
    i_IF_PC = 32'h400;
    write_entry(32'h208, 32'h1000, 2'b10);
    write_entry(32'h20C, 32'h1004, 2'b10);
    write_entry(32'h210, 32'h1008, 2'b10);
    write_entry(32'h214, 32'h100C, 2'b10);
    look("fill_hit", 32'h214, 1'b1);
    i_Inval       = 1'b1;
    i_WriteEnable = 1'b1;
    i_Upd_PC      = 32'h218;
    i_Upd_Target  = 32'h1010;
    i_CtrlOut     = 2'b11;
    @(negedge clk);
    i_Inval       = 1'b0;
    i_WriteEnable = 1'b0;
    look("inval_208", 32'h208, 1'b0);
    look("inval_20c", 32'h20C, 1'b0);
    look("inval_210", 32'h210, 1'b0);
    look("inval_214", 32'h214, 1'b0);
    look("inval_218", 32'h218, 1'b0);
    look("inval_140", 32'h140, 1'b0);
    @(negedge clk);
    look("inval_218_later", 32'h218, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
